// File: rtl/axi4_burst_addr_gen_pkg.sv
// Shared AXI4 burst/size encodings and burst-generator constants.
// Imported by the beat address generator and its strobe helper.
package axi4_burst_addr_gen_pkg;

  typedef enum logic [1:0] {
    AXI4_BURST_FIXED    = 2'b00,
    AXI4_BURST_INCR     = 2'b01,
    AXI4_BURST_WRAP     = 2'b10,
    AXI4_BURST_RESERVED = 2'b11
  } awburst_e;
  typedef awburst_e arburst_e;

  typedef enum logic [2:0] {
    AXI4_SIZE_1B   = 3'd0,
    AXI4_SIZE_2B   = 3'd1,
    AXI4_SIZE_4B   = 3'd2,
    AXI4_SIZE_8B   = 3'd3,
    AXI4_SIZE_16B  = 3'd4,
    AXI4_SIZE_32B  = 3'd5,
    AXI4_SIZE_64B  = 3'd6,
    AXI4_SIZE_128B = 3'd7
  } awsize_e;
  typedef awsize_e arsize_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } axi4_burst_gen_state_e;

  localparam int AXI4_BOUNDARY_BYTES = 4096;
  localparam int AXI4_MAX_FIXED_LEN  = 15;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen_strb_calc.sv
// Byte-lane mask for one beat: lanes from the address offset up to the
// end of the size-aligned container that holds the address.
module axi4_beat_strb_calc
  import axi4_burst_addr_gen_pkg::*;
#(
  parameter int STROBE_WIDTH = 4,
  parameter int LOW_W        = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1
) (
  input  logic [LOW_W-1:0]        addr_low,
  input  logic [2:0]              size,
  output logic [STROBE_WIDTH-1:0] strb
);

  logic [8:0] off;
  logic [8:0] bytes;
  logic [8:0] lane_end;

  always_comb begin
    strb     = '0;
    off      = 9'(addr_low);
    bytes    = 9'd1 << size;
    lane_end = (off & ~(bytes - 9'd1)) + bytes;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      strb[i] = (9'(i) >= off) && (9'(i) < lane_end);
    end
  end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat AXI4 address/strobe generator: one command in, len+1 beat
// descriptors out, with FIXED/INCR/WRAP arithmetic and legality flagging.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a burst command
//   BURST | beat descriptor valid, advancing on each beat_ready
module axi4_burst_addr_gen
  import axi4_burst_addr_gen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int STROBE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  input  logic [1:0]               cmd_burst,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic [ADDRESS_WIDTH-1:0] beat_addr,
  output logic [7:0]               beat_idx,
  output logic                     beat_last,
  output logic [STROBE_WIDTH-1:0]  beat_strb,
  output logic                     beat_err,
  output logic                     busy
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int LOW_W = (STROBE_WIDTH > 1) ? $clog2(STROBE_WIDTH) : 1;

  axi4_burst_gen_state_e state;
  logic [7:0]    len_q;
  logic [2:0]    size_q;
  awburst_e      burst_q;
  logic [AW-1:0] wrap_lower_q;
  logic [AW-1:0] wrap_upper_q;

  awburst_e      burst_in;
  logic [7:0]    bytes_in;
  logic [AW-1:0] bmask_in;
  logic [8:0]    beats_in;
  logic [16:0]   span_4k;
  logic [11:0]   wrap_w;
  logic [AW-1:0] wrap_lower;
  logic [AW-1:0] wrap_upper;
  logic          err_in;

  logic [7:0]    bytes_q;
  logic [AW-1:0] bmask_q;
  logic [AW-1:0] wrap_inc;
  logic [AW-1:0] next_addr;

  logic [LOW_W-1:0]        sel_low;
  logic [2:0]              sel_size;
  logic [STROBE_WIDTH-1:0] strb_calc;

  assign burst_in = awburst_e'(cmd_burst);

  // Legality and wrap bounds are derived from the raw command while idle.
  // The span sum is kept wide enough that it can never wrap for any
  // len/size combination, so the boundary compare is always exact.
  always_comb begin
    bytes_in   = 8'd1 << cmd_size;
    bmask_in   = {{(AW-8){1'b0}}, bytes_in - 8'd1};
    beats_in   = {1'b0, cmd_len} + 9'd1;
    span_4k    = 17'(cmd_addr[11:0] & ~bmask_in[11:0]) + (17'(beats_in) << cmd_size);
    wrap_w     = 12'(beats_in) << cmd_size;
    wrap_lower = cmd_addr & ~{{(AW-12){1'b0}}, wrap_w - 12'd1};
    wrap_upper = wrap_lower + {{(AW-12){1'b0}}, wrap_w};
    err_in     = (burst_in == AXI4_BURST_RESERVED)
              || (9'(bytes_in) > 9'(STROBE_WIDTH))
              || ((burst_in == AXI4_BURST_WRAP) && !wrap_len_ok(cmd_len))
              || ((burst_in == AXI4_BURST_WRAP) && ((cmd_addr & bmask_in) != '0))
              || ((burst_in == AXI4_BURST_FIXED) && (cmd_len > 8'(AXI4_MAX_FIXED_LEN)))
              || ((burst_in == AXI4_BURST_INCR) && (span_4k > 17'(AXI4_BOUNDARY_BYTES)));
  end

  // Reserved bursts still drain len+1 beats; they step like INCR.
  always_comb begin
    bytes_q   = 8'd1 << size_q;
    bmask_q   = {{(AW-8){1'b0}}, bytes_q - 8'd1};
    wrap_inc  = beat_addr + {{(AW-8){1'b0}}, bytes_q};
    next_addr = (beat_addr & ~bmask_q) + {{(AW-8){1'b0}}, bytes_q};
    case (burst_q)
      AXI4_BURST_FIXED: next_addr = beat_addr;
      AXI4_BURST_WRAP:  next_addr = (wrap_inc == wrap_upper_q) ? wrap_lower_q : wrap_inc;
      default:          ;
    endcase
  end

  always_comb begin
    sel_low  = (state == IDLE) ? cmd_addr[LOW_W-1:0] : next_addr[LOW_W-1:0];
    sel_size = (state == IDLE) ? cmd_size : size_q;
  end

  axi4_beat_strb_calc #(
    .STROBE_WIDTH (STROBE_WIDTH),
    .LOW_W        (LOW_W)
  ) u_strb_calc (
    .addr_low (sel_low),
    .size     (sel_size),
    .strb     (strb_calc)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      beat_valid   <= 1'b0;
      beat_id      <= '0;
      beat_addr    <= '0;
      beat_idx     <= '0;
      beat_last    <= 1'b0;
      beat_strb    <= '0;
      beat_err     <= 1'b0;
      busy         <= 1'b0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= AXI4_BURST_FIXED;
      wrap_lower_q <= '0;
      wrap_upper_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state        <= BURST;
            cmd_ready    <= 1'b0;
            beat_valid   <= 1'b1;
            busy         <= 1'b1;
            beat_id      <= cmd_id;
            beat_addr    <= cmd_addr;
            beat_idx     <= 8'd0;
            beat_last    <= (cmd_len == 8'd0);
            beat_err     <= err_in;
            beat_strb    <= err_in ? '0 : strb_calc;
            len_q        <= cmd_len;
            size_q       <= cmd_size;
            burst_q      <= burst_in;
            wrap_lower_q <= wrap_lower;
            wrap_upper_q <= wrap_upper;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        BURST: begin
          if (beat_ready) begin
            if (beat_last) begin
              state      <= IDLE;
              cmd_ready  <= 1'b1;
              beat_valid <= 1'b0;
              beat_last  <= 1'b0;
              busy       <= 1'b0;
            end else begin
              beat_addr <= next_addr;
              beat_idx  <= beat_idx + 8'd1;
              beat_last <= ((beat_idx + 8'd1) == len_q);
              beat_strb <= beat_err ? '0 : strb_calc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench: directed cases plus randomized bursts compared
// against a burst-level reference model of the beat sequence.
module tb_axi4_burst_addr_gen;

  localparam int AW = 32;
  localparam int SW = 4;
  localparam int IW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [2:0]    cmd_size = '0;
  logic [1:0]    cmd_burst = '0;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [IW-1:0] beat_id;
  logic [AW-1:0] beat_addr;
  logic [7:0]    beat_idx;
  logic          beat_last;
  logic [SW-1:0] beat_strb;
  logic          beat_err;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] exp_addr [256];
  logic [SW-1:0] exp_strb [256];
  logic          exp_err;

  axi4_burst_addr_gen #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (32),
    .ID_WIDTH      (IW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .beat_strb  (beat_strb),
    .beat_err   (beat_err),
    .busy       (busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_strb(input logic [AW-1:0] a, input logic [31:0] b);
    logic [32:0] lo, hi, byte_a;
    logic [SW-1:0] m;
    m  = '0;
    lo = {1'b0, a};
    hi = {1'b0, a & ~(b - 32'd1)} + {1'b0, b};
    for (int i = 0; i < SW; i++) begin
      byte_a = {1'b0, a & ~32'(SW - 1)} + 33'(i);
      m[i]   = (byte_a >= lo) && (byte_a < hi);
    end
    return m;
  endfunction

  // Expected beat sequence from the burst rules, computed per beat number.
  task automatic build_model(input logic [AW-1:0] addr, input int len, input int size, input int burst);
    logic [31:0] b, aligned, w, lower, cur, nxt, a;
    b       = 32'd1 << size;
    aligned = addr & ~(b - 32'd1);
    w       = 32'(len + 1) * b;
    lower   = addr & ~(w - 32'd1);
    exp_err = (burst == 3) || (b > 32'(SW))
           || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
           || (burst == 2 && addr != aligned)
           || (burst == 0 && len > 15)
           || (burst == 1 && (((addr & 32'hFFF) & ~(b - 32'd1)) + 32'(len + 1) * b) > 32'd4096);
    cur = addr;
    for (int n = 0; n <= len; n++) begin
      if (burst == 0)      a = addr;
      else if (burst == 2) a = cur;
      else                 a = (n == 0) ? addr : aligned + 32'(n) * b;
      exp_addr[n] = a;
      exp_strb[n] = exp_err ? '0 : model_strb(a, b);
      nxt = cur + b;
      cur = (nxt == lower + w) ? lower : nxt;
    end
  endtask

  task automatic issue(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                       input int size, input int burst);
    int guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    cmd_size  = 3'(size);
    cmd_burst = 2'(burst);
    @(negedge aclk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    chk("beat_valid_latency", 64'(beat_valid), 64'd1);
  endtask

  task automatic chk_beat(input logic [IW-1:0] id, input int k, input int len);
    chk("beat_valid", 64'(beat_valid), 64'd1);
    chk("beat_addr", 64'(beat_addr), 64'(exp_addr[k]));
    chk("beat_idx", 64'(beat_idx), 64'(k));
    chk("beat_last", 64'(beat_last), 64'(k == len));
    chk("beat_strb", 64'(beat_strb), 64'(exp_strb[k]));
    chk("beat_err", 64'(beat_err), 64'(exp_err));
    chk("beat_id", 64'(beat_id), 64'(id));
    chk("busy_burst", 64'(busy), 64'd1);
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: 3-cycle stall at beat 1
  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input int size, input int burst, input int mode);
    int k = 0;
    int stall = 0;
    int cyc = 0;
    logic r;
    build_model(addr, len, size, burst);
    issue(id, addr, len, size, burst);
    while (k <= len && cyc < 2000) begin
      if (mode == 1)                     r = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && k == 1 && stall < 3) begin
        r = 1'b0;
        stall++;
      end else                           r = 1'b1;
      beat_ready = r;
      chk_beat(id, k, len);
      @(negedge aclk);
      if (r) k++;
      cyc++;
    end
    if (cyc >= 2000) chk("burst_timeout", 64'(k), 64'(len + 1));
    beat_ready = 1'b0;
    chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
    chk("beat_valid_after", 64'(beat_valid), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int len, size, burst, mode;
    logic [AW-1:0] addr;
    int wlens [5] = '{1, 2, 3, 7, 15};

    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_beat_valid", 64'(beat_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_beat_fields", {beat_addr, 4'(beat_id), beat_idx, beat_last, 4'(beat_strb), beat_err},
        64'd0);
    aresetn = 1'b1;
    #1;
    chk("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge aclk);
    chk("cmd_ready_first_edge", 64'(cmd_ready), 64'd1);

    run_burst(4'h1, 32'h0000_1002, 3, 2, 1, 0);
    run_burst(4'h2, 32'h0000_0038, 3, 2, 2, 0);
    run_burst(4'h3, 32'h0000_0202, 2, 1, 0, 0);
    run_burst(4'h4, 32'h0000_0FF8, 3, 2, 1, 0);
    run_burst(4'h5, 32'h0000_0038, 2, 2, 2, 0);
    run_burst(4'h6, 32'h0000_0100, 15, 0, 0, 0);
    run_burst(4'h7, 32'h0000_0100, 16, 0, 0, 0);
    run_burst(4'h8, 32'h0000_0040, 0, 3, 1, 0);
    run_burst(4'h9, 32'h0000_0010, 1, 2, 3, 0);
    run_burst(4'hA, 32'h0000_2004, 4, 2, 1, 2);

    // Reset while beat 2 is presented.
    build_model(32'h0000_3000, 5, 2, 1);
    issue(4'hB, 32'h0000_3000, 5, 2, 1);
    beat_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_beat(4'hB, k, 5);
      if (k < 2) @(negedge aclk);
    end
    aresetn = 1'b0;
    #1;
    chk("midrst_beat_valid", 64'(beat_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_beat_last", 64'(beat_last), 64'd0);
    beat_ready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_idle_valid", 64'(beat_valid), 64'd0);
    run_burst(4'hC, 32'h0000_4008, 2, 2, 1, 0);

    for (int t = 0; t < 40; t++) begin
      burst = $urandom_range(0, 3);
      size  = $urandom_range(0, 3);
      mode  = $urandom_range(0, 2);
      addr  = $urandom;
      if ($urandom_range(0, 2) == 0) addr[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      case (burst)
        0:       len = $urandom_range(0, 20);
        2: begin
          len = wlens[$urandom_range(0, 4)];
          if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
        end
        default: len = $urandom_range(0, 40);
      endcase
      run_burst(4'($urandom), addr, len, size, burst, mode);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
